// File: rtl/conv_pkg.sv
// Shared widths, FSM state type, column/sum payloads and kernel weights for the 3x3 filter.
// CONV3X3_SOBEL_EN selects the Sobel-magnitude sum layout instead of the Gaussian one.
package conv_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned IMG_W    = 64;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned K_CORNER = 1;
  localparam int unsigned K_EDGE   = 2;
  localparam int unsigned WSUM_W   = PIX_W + 2;
  localparam int unsigned GSUM_W   = PIX_W + 4;
  localparam int unsigned GRAD_W   = PIX_W + 3;

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_e;

  // One vertical column: bottom row in the high byte, top row in the low byte
  typedef struct packed {
    logic [PIX_W-1:0] bot;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] top;
  } col_t;

  typedef struct packed {
`ifdef CONV3X3_SOBEL_EN
    logic [GRAD_W-1:0] gx;
    logic [GRAD_W-1:0] gy;
`else
    logic [GSUM_W-1:0] gsum;
`endif
  } sums_t;

  // 1-2-1 weighted sum of three pixels
  function automatic logic [WSUM_W-1:0] wsum121(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
    return WSUM_W'(a) * WSUM_W'(K_CORNER) + WSUM_W'(b) * WSUM_W'(K_EDGE)
         + WSUM_W'(c) * WSUM_W'(K_CORNER);
  endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// Column-in / pixel-out bus of the 3x3 filter; master drives columns, slave is the filter.
interface conv3x3_filter_if;
  import conv_pkg::*;

  logic             in_valid;
  col_t             three_rows;
  logic [COL_W-1:0] in_col;
  logic             out_valid;
  logic [PIX_W-1:0] pixel_out;
  logic [COL_W-1:0] out_col;

  modport master (output in_valid, three_rows, in_col,
                  input  out_valid, pixel_out, out_col);
  modport slave  (input  in_valid, three_rows, in_col,
                  output out_valid, pixel_out, out_col);
endinterface

// File: rtl/conv3x3_kernel.sv
// Stage-1 arithmetic: combinational window sums (Gaussian, or Gx/Gy with CONV3X3_SOBEL_EN).
module conv3x3_kernel
  import conv_pkg::*;
(
  input  col_t  w0,
  input  col_t  w1,
  input  col_t  w2,
  output sums_t sums
);

`ifdef CONV3X3_SOBEL_EN
  logic [WSUM_W-1:0] right_c, left_c, bot_c, top_c;

  // Gx: right column minus left column; Gy: bottom row minus top row
  always_comb begin
    right_c = wsum121(w0.top, w0.mid, w0.bot);
    left_c  = wsum121(w2.top, w2.mid, w2.bot);
    bot_c   = wsum121(w2.bot, w1.bot, w0.bot);
    top_c   = wsum121(w2.top, w1.top, w0.top);
    sums.gx = GRAD_W'(right_c) - GRAD_W'(left_c);
    sums.gy = GRAD_W'(bot_c) - GRAD_W'(top_c);
  end
`else
  // Separable 1-2-1 x 1-2-1 kernel
  always_comb begin
    sums.gsum = GSUM_W'(wsum121(w2.top, w2.mid, w2.bot))
              + GSUM_W'(wsum121(w1.top, w1.mid, w1.bot)) * GSUM_W'(K_EDGE)
              + GSUM_W'(wsum121(w0.top, w0.mid, w0.bot));
  end
`endif

endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 streaming filter: column window, fill FSM, two-stage compute pipeline.
// Gaussian by default; define CONV3X3_SOBEL_EN for clamped Sobel magnitude.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = conv_pkg::PIX_W,
  parameter int unsigned IMG_W = conv_pkg::IMG_W
) (
  input logic             clk,
  input logic             reset,
  conv3x3_filter_if.slave bus
);

  localparam int unsigned COL_L   = $clog2(IMG_W);
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  state_e           state, state_next;
  logic             restart_c, issue_c;
  col_t             w0, w1, w2;
  logic [COL_L-1:0] last_col;
  logic             v0, v1;
  logic [COL_W-1:0] col0, col1;
  sums_t            sums, s1;
  logic [PIX_W-1:0] pix_c;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A column restarts the window unless it directly follows the previous one
  always_comb begin
    state_next = state;
    restart_c  = 1'b0;
    if (bus.in_valid) begin
      restart_c = (bus.in_col == '0) || (state == IDLE) ||
                  (bus.in_col != COL_L'(last_col + 1'b1));
      if (restart_c) begin
        state_next = FILL1;
      end else begin
        case (state)
          FILL1:   state_next = FILL2;
          FILL2:   state_next = RUN;
          default: state_next = RUN;
        endcase
      end
    end
  end

  always_comb begin
    issue_c = 1'b0;
    if (bus.in_valid && (state_next == RUN)) issue_c = 1'b1;
  end

  conv3x3_kernel u_kernel (
    .w0   (w0),
    .w1   (w1),
    .w2   (w2),
    .sums (sums)
  );

`ifdef CONV3X3_SOBEL_EN
  logic [GRAD_W-1:0] ax_c, ay_c;
  logic [GRAD_W:0]   mag_c;

  always_comb begin
    ax_c  = s1.gx[GRAD_W-1] ? GRAD_W'(-s1.gx) : s1.gx;
    ay_c  = s1.gy[GRAD_W-1] ? GRAD_W'(-s1.gy) : s1.gy;
    mag_c = (GRAD_W+1)'(ax_c) + (GRAD_W+1)'(ay_c);
    pix_c = (mag_c > (GRAD_W+1)'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(mag_c);
  end
`else
  always_comb pix_c = PIX_W'(s1.gsum >> 4);
`endif

  // Window shift, then issue flag -> stage-1 sums -> stage-2 result
  always_ff @(posedge clk) begin
    if (reset) begin
      w0            <= '0;
      w1            <= '0;
      w2            <= '0;
      last_col      <= '0;
      v0            <= 1'b0;
      col0          <= '0;
      v1            <= 1'b0;
      col1          <= '0;
      s1            <= '0;
      bus.out_valid <= 1'b0;
      bus.pixel_out <= '0;
      bus.out_col   <= '0;
    end else begin
      if (bus.in_valid) begin
        w2       <= w1;
        w1       <= w0;
        w0       <= bus.three_rows;
        last_col <= COL_L'(bus.in_col);
      end
      v0 <= issue_c;
      if (issue_c) col0 <= COL_W'(bus.in_col - 1'b1);
      v1 <= v0;
      if (v0) begin
        s1   <= sums;
        col1 <= col0;
      end
      bus.out_valid <= v1;
      if (v1) begin
        bus.pixel_out <= pix_c;
        bus.out_col   <= col1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Randomised self-checking bench for conv3x3_filter against a window-level reference model.
module tb_conv3x3_filter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv3x3_filter_if bus ();

  conv3x3_filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int col;
    int pix;
    int due;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          n_out  = 0;
  int          last_pix  = 0;
  int          last_ocol = 0;
  exp_t        exp_q[$];
  int          hist_col[$];
  logic [23:0] hist_dat[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Filter value of a window given as left, centre, right columns
  function automatic int ref_pix(input logic [23:0] l, input logic [23:0] c, input logic [23:0] r);
    int          p[3][3];
    int          w[3] = '{1, 2, 1};
    logic [23:0] cols[3];
    int          s, gx, gy;
    cols[0] = l; cols[1] = c; cols[2] = r;
    for (int k = 0; k < 3; k++)
      for (int row = 0; row < 3; row++)
        p[row][k] = int'(cols[k][row*8 +: 8]);
`ifdef CONV3X3_SOBEL_EN
    gx = 0; gy = 0;
    for (int i = 0; i < 3; i++) begin
      gx += w[i] * (p[i][2] - p[i][0]);
      gy += w[i] * (p[2][i] - p[0][i]);
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    return (s > 255) ? 255 : s;
`else
    s = 0;
    for (int row = 0; row < 3; row++)
      for (int k = 0; k < 3; k++)
        s += w[row] * w[k] * p[row][k];
    return s / 16;
`endif
  endfunction

  // One clock: drive, update the model for this edge, check outputs just after it
  task automatic step(input bit v, input int col, input logic [23:0] dat, input bit rst);
    bit   exp_v;
    exp_t e;
    bus.in_valid   = v;
    bus.in_col     = 6'(col);
    bus.three_rows = dat;
    reset          = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      hist_col.delete();
      hist_dat.delete();
      last_pix  = 0;
      last_ocol = 0;
    end else if (v) begin
      hist_col.push_back(col);
      hist_dat.push_back(dat);
      if (hist_col.size() > 3) begin
        void'(hist_col.pop_front());
        void'(hist_dat.pop_front());
      end
      if (hist_col.size() == 3 && hist_col[1] == hist_col[0] + 1 && hist_col[2] == hist_col[1] + 1)
        exp_q.push_back('{col - 1, ref_pix(hist_dat[0], hist_dat[1], hist_dat[2]), cyc + 2});
    end
    #1;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check_eq("out_valid", int'(bus.out_valid), int'(exp_v));
    if (bus.out_valid) n_out++;
    if (exp_v) begin
      e = exp_q.pop_front();
      check_eq("pixel_out", int'(bus.pixel_out), e.pix);
      check_eq("out_col", int'(bus.out_col), e.col);
      last_pix  = e.pix;
      last_ocol = e.col;
    end else begin
      check_eq("pixel_hold", int'(bus.pixel_out), last_pix);
      check_eq("out_col_hold", int'(bus.out_col), last_ocol);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 24'(0), 1'b0);
  endtask

  initial begin
    int c;
    int r;
    step(1'b0, 0, 24'(0), 1'b1);
    step(1'b0, 0, 24'(0), 1'b1);

    n_out = 0;
    for (int i = 0; i < 64; i++) step(1'b1, i, {3{8'd100}}, 1'b0);
    idle(3);
    check_eq("row_output_count", n_out, 62);

    for (int i = 0; i < 64; i++) step(1'b1, i, (i < 32) ? 24'h000000 : 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 64; i++) step(1'b1, i, 24'hFFFF00, 1'b0);
    idle(3);

    repeat (2) begin
      for (int i = 0; i < 64; i++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, i, 24'($urandom), 1'b0);
        step(1'b1, i, 24'($urandom), 1'b0);
      end
    end
    idle(3);

    for (int i = 0; i <= 10; i++) step(1'b1, i, 24'($urandom), 1'b0);
    idle(3);
    for (int i = 11; i <= 15; i++) step(1'b1, i, 24'($urandom), 1'b0);
    idle(3);

    for (int i = 0; i <= 10; i++) step(1'b1, i, 24'($urandom), 1'b0);
    for (int i = 20; i <= 25; i++) step(1'b1, i, 24'($urandom), 1'b0);
    idle(3);

    for (int i = 0; i <= 5; i++) step(1'b1, i, 24'($urandom), 1'b0);
    step(1'b1, 6, 24'($urandom), 1'b1);
    for (int i = 7; i <= 12; i++) step(1'b1, i, 24'($urandom), 1'b0);
    idle(3);

    c = 0;
    repeat (400) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        step(1'b0, c, 24'($urandom), 1'b0);
      end else begin
        if (r == 1) c = int'($urandom_range(0, 63));
        step(1'b1, c, 24'($urandom), (r == 2) && ($urandom_range(0, 7) == 0));
        c = (c + 1) % 64;
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 64: image width in pixels; column index width is 6.
REQ-003 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: three_rows and in_col are valid this cycle (driven by the upstream row-storage flag, qualified per column).
REQ-006 Port three_rows, input, 24: vertical pixel column; [7:0]=top (row-2), [15:8]=middle (row-1), [23:16]=bottom (row).
REQ-007 Port in_col, input, 6: column index of three_rows, 0..63.
REQ-008 Port out_valid, output, 1: pixel_out and out_col are valid this cycle.
REQ-009 Port pixel_out, output, 8: filtered centre pixel.
REQ-010 Port out_col, output, 6: column of the window centre (in_col of the completing column minus 1).

Function
REQ-011 The block SHALL hold a 3-column window W0 (newest, right), W1 (centre), W2 (left); each accepted column SHALL shift W0->W1->W2.
REQ-012 Column acceptance: in_valid=1 SHALL accept a column; in_valid=0 SHALL hold the window and create a pipeline bubble.
REQ-013 The FSM SHALL have states IDLE, FILL1, FILL2, RUN.
REQ-014 On an accepted column with in_col==0, any column in IDLE, or in_col != last_col+1, the FSM SHALL go to FILL1, with that column as the first column of a new window.
REQ-015 Otherwise, accepted columns SHALL advance the FSM FILL1->FILL2 and FILL2->RUN; RUN stays in RUN.
REQ-016 A compute SHALL be issued only for an accepted column that leaves the FSM in RUN, i.e. whose window holds 3 contiguous columns.
REQ-017 The pipeline SHALL have 2 register stages: stage 1 forms signed/unsigned sums, stage 2 normalises or clamps.
REQ-018 out_valid SHALL assert exactly 2 rising edges after the edge that accepts the completing column; there is no back-pressure.
REQ-019 Per row, columns 0..63 SHALL yield 62 outputs, with out_col 1..62.
REQ-020 Boundary pixels (out_col 0, 63) SHALL never be produced.
REQ-021 The default filter SHALL be Gaussian, kernel [1 2 1; 2 4 2; 1 2 1]; the 12-bit sum SHALL be shifted right 4 with truncation, so the result is at most 255.
REQ-022 When out_valid=0, pixel_out and out_col SHALL hold their last values.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL go to IDLE.
REQ-024 On that edge, the window, pipeline registers, out_valid, pixel_out and out_col SHALL be cleared to 0.
REQ-025 Reset SHALL take priority over a simultaneous in_valid; that column SHALL be discarded.
REQ-026 Reset mid-RUN SHALL flush in-flight computes; no out_valid SHALL appear from pre-reset columns.

Configuration
REQ-027 With macro CONV3X3_SOBEL_EN defined, the filter SHALL be Sobel magnitude |Gx|+|Gy|, clamped to 255.
REQ-028 Gx SHALL be (W0 weighted 1,2,1) minus (W2 weighted 1,2,1), signed 11 bits.
REQ-029 Gy SHALL be (bottom row weighted 1,2,1 across W2,W1,W0) minus (top row weighted the same), signed 11 bits.
REQ-030 Without CONV3X3_SOBEL_EN, only the Gaussian path of REQ-021 SHALL exist.
REQ-031 Latency and interface SHALL be identical in both builds.

Structure
REQ-032 Shared package conv_pkg SHALL hold PIX_W, IMG_W, the FSM state typedef, and the kernel weight constants.
REQ-033 Sub-module conv3x3_kernel SHALL implement the stage-1 arithmetic (window in, sums out).
REQ-034 FSM, window and stage-2 logic SHALL live in conv3x3_filter.

Verification
REQ-035 Gaussian build, uniform 100 in all columns 0..63 back-to-back -> first out_valid 2 edges after col 2 is accepted, out_col=1, pixel_out=100; 62 outputs total.
REQ-036 Sobel build, columns 0..31 =0 and 32..63 =255 -> pixel_out=255 at out_col 31 and 32 (Gx=1020 clamped); pixel_out=0 elsewhere.
REQ-037 Sobel build, top byte 0 and middle/bottom bytes 255 in all columns -> pixel_out=255 for every output (Gy=1020).
REQ-038 in_valid low for 3 cycles after col 10 -> no out_valid in the bubble; col 11 then gives out_col=10, value unaffected.
REQ-039 in_col jump 10->20 -> cols 20 and 21 give no output; col 22 gives out_col=21.
REQ-040 Reset pulse in RUN with two computes in flight -> out_valid=0 and pixel_out=0 on the next edge, no stale output; the next column after reset enters FILL1.
